// File: rtl/cosine_sim_pkg.sv
// Shared types, FP32 constants and helpers for the streaming cosine-similarity engine.
package cosine_sim_pkg;

   typedef enum logic [2:0] {IDLE, ACC, SQRT, DEN, DIV, OUT} state_t;

   localparam logic [31:0] FP_ZERO = 32'h00000000;
   localparam logic [31:0] FP_ONE  = 32'h3F800000;
   localparam logic [31:0] FP_NAN  = 32'h7FC00000;
   localparam logic [31:0] FP_INF  = 32'h7F800000;

   function automatic logic fp_is_zero(input logic [31:0] x);
      return x[30:0] == 31'd0;
   endfunction

   // Round-to-nearest-even on a 24-bit significand (hidden bit at [23]); flushes underflow to zero.
   function automatic logic [31:0] fp_round(input logic s, input logic signed [10:0] e,
                                            input logic [23:0] m, input logic g, input logic st);
      logic [24:0]        r;
      logic signed [10:0] ee;
      r  = {1'b0, m} + {24'd0, g & (st | m[0])};
      ee = e;
      if (r[24]) begin
         ee = e + 11'sd1;
         r  = r >> 1;
      end
      if (ee >= 11'sd255) return {s, FP_INF[30:0]};
      if (ee <= 11'sd0)   return {s, 31'd0};
      return {s, ee[7:0], r[22:0]};
   endfunction

endpackage

// File: rtl/cosine_sim_fp.sv
// Combinational FP32 multiply, add, sqrt and divide cores (RNE, subnormals flushed to zero).
module FloatingMultiplication import cosine_sim_pkg::*; (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   logic               s;
   logic [7:0]         ea, eb;
   logic [47:0]        p;
   logic signed [10:0] e;

   always_comb begin
      s  = a[31] ^ b[31];
      ea = a[30:23];
      eb = b[30:23];
      p  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e  = 11'(ea) + 11'(eb) - 11'd127;
      if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0))
         result = FP_NAN;
      else if (ea == 8'hFF || eb == 8'hFF)
         result = (ea == 8'd0 || eb == 8'd0) ? FP_NAN : {s, FP_INF[30:0]};
      else if (ea == 8'd0 || eb == 8'd0)
         result = {s, 31'd0};
      else if (p[47])
         result = fp_round(s, e + 11'sd1, p[47:24], p[23], |p[22:0]);
      else
         result = fp_round(s, e, p[46:23], p[22], |p[21:0]);
   end
endmodule

module FloatingAddition import cosine_sim_pkg::*; (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   logic               swap, nan_a, nan_b, inf_a, inf_b;
   logic [31:0]        big, sml;
   logic [7:0]         d8;
   logic [58:0]        wide;
   logic [26:0]        ml, al, n;
   logic [27:0]        sm;
   logic [4:0]         msb, sh;
   logic signed [10:0] e;

   always_comb begin
      nan_a = (&a[30:23]) && (|a[22:0]);
      nan_b = (&b[30:23]) && (|b[22:0]);
      inf_a = (&a[30:23]) && !(|a[22:0]);
      inf_b = (&b[30:23]) && !(|b[22:0]);
      swap  = b[30:0] > a[30:0];
      big   = swap ? b : a;
      sml   = swap ? a : b;
      d8    = big[30:23] - sml[30:23];
      // Extra low bits catch everything shifted out so the sticky bit is exact.
      wide  = {1'b1, sml[22:0], 35'd0} >> ((d8 > 8'd31) ? 8'd31 : d8);
      al    = wide[58:32];
      al[0] = al[0] | (|wide[31:0]);
      ml    = {1'b1, big[22:0], 3'b000};
      sm    = (big[31] == sml[31]) ? {1'b0, ml} + {1'b0, al} : {1'b0, ml} - {1'b0, al};
      msb   = 5'd0;
      for (int i = 0; i < 28; i++)
         if (sm[i]) msb = 5'(i);
      sh = 5'd26 - msb;
      e  = {3'b000, big[30:23]};
      if (msb == 5'd27) begin
         n    = sm[27:1];
         n[0] = n[0] | sm[0];
         e    = e + 11'sd1;
      end else begin
         n = sm[26:0] << sh;
         e = e - {6'd0, sh};
      end
      if (nan_a || nan_b)             result = FP_NAN;
      else if (inf_a && inf_b)        result = (a[31] != b[31]) ? FP_NAN : a;
      else if (inf_a)                 result = a;
      else if (inf_b)                 result = b;
      else if (a[30:23] == 8'd0)      result = (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
      else if (b[30:23] == 8'd0)      result = a;
      else if (sm == 28'd0)           result = FP_ZERO;
      else                            result = fp_round(big[31], e, n[26:3], n[2], |n[1:0]);
   end
endmodule

module FloatingSqrt import cosine_sim_pkg::*; (
   input  logic [31:0] a,
   output logic [31:0] result
);
   logic [49:0]        rad;
   logic [51:0]        rem, trial;
   logic [24:0]        res;
   logic signed [10:0] re;

   always_comb begin
      // Make the unbiased exponent even before taking the digit-by-digit root.
      if (a[23]) rad = {1'b0, 1'b1, a[22:0], 25'd0};
      else       rad = {1'b1, a[22:0], 26'd0};
      re  = {3'b000, 8'(({1'b0, a[30:23]} + (a[23] ? 9'd127 : 9'd126)) >> 1)};
      rem = 52'd0;
      res = 25'd0;
      for (int i = 24; i >= 0; i--) begin
         rem   = {rem[49:0], rad[2*i +: 2]};
         trial = {25'd0, res, 2'b01};
         if (rem >= trial) begin
            rem = rem - trial;
            res = {res[23:0], 1'b1};
         end else begin
            res = {res[23:0], 1'b0};
         end
      end
      if ((&a[30:23]) && (|a[22:0]))  result = FP_NAN;
      else if (a[30:23] == 8'd0)      result = {a[31], 31'd0};
      else if (a[31])                 result = FP_NAN;
      else if (&a[30:23])             result = FP_INF;
      else                            result = fp_round(1'b0, re, res[24:1], res[0], rem != 52'd0);
   end
endmodule

module FloatingDivision import cosine_sim_pkg::*; (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   logic               s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [25:0]        rem;
   logic [23:0]        mb;
   logic [26:0]        q;
   logic signed [10:0] e;

   always_comb begin
      s      = a[31] ^ b[31];
      nan_a  = (&a[30:23]) && (|a[22:0]);
      nan_b  = (&b[30:23]) && (|b[22:0]);
      inf_a  = (&a[30:23]) && !(|a[22:0]);
      inf_b  = (&b[30:23]) && !(|b[22:0]);
      zero_a = a[30:23] == 8'd0;
      zero_b = b[30:23] == 8'd0;
      mb     = {1'b1, b[22:0]};
      rem    = {2'b00, 1'b1, a[22:0]};
      q      = 27'd0;
      for (int i = 26; i >= 0; i--) begin
         if (rem >= {2'b00, mb}) begin
            q[i] = 1'b1;
            rem  = rem - {2'b00, mb};
         end
         rem = rem << 1;
      end
      e = 11'(a[30:23]) - 11'(b[30:23]) + 11'd127;
      if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) result = FP_NAN;
      else if (inf_a || zero_b)  result = {s, FP_INF[30:0]};
      else if (zero_a || inf_b)  result = {s, 31'd0};
      else if (q[26])            result = fp_round(s, e, q[26:3], q[2], (|q[1:0]) | (rem != 26'd0));
      else                       result = fp_round(s, e - 11'd1, q[25:2], q[1], q[0] | (rem != 26'd0));
   end
endmodule

// File: rtl/cosine_sim_mac.sv
// One FP32 multiply-accumulate lane: acc <= acc + x*y when en, zeroed by clr.
module cosine_sim_mac import cosine_sim_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [31:0] acc
);
   logic [31:0] prod, sum;

   FloatingMultiplication u_mul (.a(x), .b(y), .result(prod));
   FloatingAddition       u_add (.a(acc), .b(prod), .result(sum));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   acc <= FP_ZERO;
      else if (clr) acc <= FP_ZERO;
      else if (en)  acc <= sum;
   end
endmodule

// File: rtl/cosine_sim_stream.sv
// Single-pass streaming FP32 cosine similarity: dot(a,b) / (|a|*|b|) with
// valid/ready input and output handshakes.
module cosine_sim_stream import cosine_sim_pkg::*; #(
   parameter int N_MAX = 16,
   parameter int LEN_W = $clog2(N_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      similarity,
   output logic             err,
   output logic             busy
);
   state_t           state;
   logic [LEN_W-1:0] len_q, cnt;
   logic [31:0]      acc_ab, acc_aa, acc_bb;
   logic [31:0]      sqrt_a, sqrt_b, den;
   logic [31:0]      sqrt_a_d, sqrt_b_d, den_d, quo_d;
   logic             legal, acc_clr, acc_en;

   assign legal   = (cfg_len != '0) && (cfg_len <= LEN_W'(N_MAX));
   assign acc_clr = (state == IDLE) && start && legal && !clear;
   assign acc_en  = in_valid && in_ready;

   cosine_sim_mac u_mac_ab (.clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .x(in_a), .y(in_b), .acc(acc_ab));
   cosine_sim_mac u_mac_aa (.clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .x(in_a), .y(in_a), .acc(acc_aa));
   cosine_sim_mac u_mac_bb (.clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .x(in_b), .y(in_b), .acc(acc_bb));

   FloatingSqrt           u_sqrt_a (.a(acc_aa), .result(sqrt_a_d));
   FloatingSqrt           u_sqrt_b (.a(acc_bb), .result(sqrt_b_d));
   FloatingMultiplication u_den    (.a(sqrt_a), .b(sqrt_b), .result(den_d));
   FloatingDivision       u_div    (.a(acc_ab), .b(den), .result(quo_d));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         similarity <= FP_ZERO;
         len_q      <= '0;
         cnt        <= '0;
         sqrt_a     <= FP_ZERO;
         sqrt_b     <= FP_ZERO;
         den        <= FP_ZERO;
      end else if (clear) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               busy <= 1'b1;
               if (legal) begin
                  state    <= ACC;
                  in_ready <= 1'b1;
                  len_q    <= cfg_len;
                  cnt      <= '0;
               end else begin
                  state      <= OUT;
                  out_valid  <= 1'b1;
                  similarity <= FP_ZERO;
                  err        <= 1'b1;
               end
            end
            // in_ready is high for the whole of ACC, so in_valid alone marks an accepted pair.
            ACC: if (in_valid) begin
               cnt <= cnt + LEN_W'(1);
               if (cnt + LEN_W'(1) == len_q) begin
                  state    <= SQRT;
                  in_ready <= 1'b0;
               end
            end
            SQRT: begin
               sqrt_a <= sqrt_a_d;
               sqrt_b <= sqrt_b_d;
               state  <= DEN;
            end
            DEN: begin
               den   <= den_d;
               state <= DIV;
            end
            DIV: begin
               if (fp_is_zero(den)) begin
                  similarity <= FP_ZERO;
                  err        <= 1'b1;
               end else begin
                  similarity <= quo_d;
                  err        <= 1'b0;
               end
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
